// File: rtl/pes_elc_sched_pkg.sv
// pes_elc_pkg: shared definitions for the pes_elc call scheduler.
//   - scheduler state encoding
//   - default floor count and door-open time
//   - floor-vector helpers: one-hot check, nearest pending floor above/below
// The helpers work on a fixed MAX_FLOORS-wide vector. Narrower floor vectors
// are zero-extended by the caller, so any NFLOORS up to MAX_FLOORS is supported.
package pes_elc_pkg;

  localparam int NFLOORS_DEF     = 8;
  localparam int DOOR_CYCLES_DEF = 4;
  localparam int MAX_FLOORS      = 32;

  typedef logic [MAX_FLOORS-1:0] floor_vec_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    DISPATCH = 2'd2,
    DOOR     = 2'd3
  } sched_state_t;

  // True when exactly one bit is set.
  function automatic logic is_onehot(input floor_vec_t v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (v[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    return seen & ~multi;
  endfunction

  // Lowest set bit of v strictly above the set bit of cur (zero if none).
  function automatic floor_vec_t lowest_above(input floor_vec_t v, input floor_vec_t cur);
    floor_vec_t r;
    logic       passed;
    logic       found;
    r      = '0;
    passed = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      // test before marking so the current floor itself is excluded
      if (passed && v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
      if (cur[i]) passed = 1'b1;
    end
    return r;
  endfunction

  // Highest set bit of v strictly below the set bit of cur (zero if none).
  function automatic floor_vec_t highest_below(input floor_vec_t v, input floor_vec_t cur);
    floor_vec_t r;
    logic       passed;
    logic       found;
    r      = '0;
    passed = 1'b0;
    found  = 1'b0;
    for (int i = MAX_FLOORS - 1; i >= 0; i--) begin
      if (passed && v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
      if (cur[i]) passed = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pes_elc_sched_if.sv
// pes_elc_sched_if: all scheduler-facing signals except clock and reset.
//   master modport: the side driving calls and controller status
//                   (call_req, cur_floor, move_complete, over_weight)
//   slave modport : the scheduler (target_floor, target_valid, dir_up,
//                   door_open, pending, busy, sched_error)
interface pes_elc_sched_if
  import pes_elc_pkg::*;
#(
  parameter int NFLOORS = NFLOORS_DEF
);

  logic [NFLOORS-1:0] call_req;
  logic [NFLOORS-1:0] cur_floor;
  logic               move_complete;
  logic               over_weight;
  logic [NFLOORS-1:0] target_floor;
  logic               target_valid;
  logic               dir_up;
  logic               door_open;
  logic [NFLOORS-1:0] pending;
  logic               busy;
  logic               sched_error;

  modport master (
    output call_req, cur_floor, move_complete, over_weight,
    input  target_floor, target_valid, dir_up, door_open, pending, busy, sched_error
  );

  modport slave (
    input  call_req, cur_floor, move_complete, over_weight,
    output target_floor, target_valid, dir_up, door_open, pending, busy, sched_error
  );

endinterface

// File: rtl/pes_elc_sched_scan_pick.sv
// pes_elc_scan_pick: combinational SCAN target choice.
//   pending   : outstanding calls (one-hot per floor)
//   cur_floor : one-hot current floor
//   dir_up    : current sweep direction
//   pick      : one-hot next target (zero if none away from this floor)
//   new_dir   : direction after the pick; flips only when the sweep reverses
//   here_hit  : a call is pending on the current floor
//   none      : nothing to serve at all
module pes_elc_scan_pick
  import pes_elc_pkg::*;
#(
  parameter int NFLOORS = NFLOORS_DEF
) (
  input  logic [NFLOORS-1:0] pending,
  input  logic [NFLOORS-1:0] cur_floor,
  input  logic               dir_up,
  output logic [NFLOORS-1:0] pick,
  output logic               new_dir,
  output logic               here_hit,
  output logic               none
);

  floor_vec_t pend_w;
  floor_vec_t cur_w;
  floor_vec_t up_w;
  floor_vec_t dn_w;

  assign pend_w = floor_vec_t'(pending);
  assign cur_w  = floor_vec_t'(cur_floor);
  assign up_w   = lowest_above(pend_w, cur_w);
  assign dn_w   = highest_below(pend_w, cur_w);

  always_comb begin
    pick    = '0;
    new_dir = dir_up;
    if (dir_up) begin
      if (|up_w) begin
        pick = NFLOORS'(up_w);
      end else if (|dn_w) begin
        pick    = NFLOORS'(dn_w);
        new_dir = 1'b0;
      end
    end else begin
      if (|dn_w) begin
        pick = NFLOORS'(dn_w);
      end else if (|up_w) begin
        pick    = NFLOORS'(up_w);
        new_dir = 1'b1;
      end
    end
  end

  assign here_hit = |(pending & cur_floor);
  assign none     = ~here_hit & ~(|pick);

endmodule

// File: rtl/pes_elc_sched.sv
// pes_elc_sched: SCAN call scheduler in front of the pes_elc controller.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : pes_elc_sched_if.slave -- calls and controller status in;
//           target/valid handshake, direction, door command, pending set,
//           busy and cur_floor sanity flag out.
// Flow: IDLE -> SELECT (one cycle) -> DISPATCH (wait arrival) -> DOOR (timed).
module pes_elc_sched
  import pes_elc_pkg::*;
#(
  parameter int NFLOORS     = NFLOORS_DEF,
  parameter int DOOR_CYCLES = DOOR_CYCLES_DEF
) (
  input logic             clk,
  input logic             reset,
  pes_elc_sched_if.slave  bus
);

  localparam int            CW        = $clog2(DOOR_CYCLES + 1);
  localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES);

  sched_state_t       state_reg, state_next;
  logic [NFLOORS-1:0] pending_reg, pending_next, pending_set;
  logic [NFLOORS-1:0] target_reg, target_next;
  logic               dir_up_reg, dir_up_next;
  logic [CW-1:0]      door_cnt_reg, door_cnt_next;
  logic               sched_error_reg;
  logic               enter_door;
  logic               in_door;
  logic               here_call;

  logic [NFLOORS-1:0] pick;
  logic               new_dir;
  logic               here_hit;
  logic               none;

  pes_elc_scan_pick #(.NFLOORS(NFLOORS)) u_pick (
    .pending   (pending_reg),
    .cur_floor (bus.cur_floor),
    .dir_up    (dir_up_reg),
    .pick      (pick),
    .new_dir   (new_dir),
    .here_hit  (here_hit),
    .none      (none)
  );

  assign in_door   = (state_reg == DOOR);
  assign here_call = |(bus.call_req & bus.cur_floor);

  // New calls are latched, except a call for the floor whose door is open:
  // that one is absorbed by keeping the door open longer.
  for (genvar gi = 0; gi < NFLOORS; gi++) begin : g_pend
    assign pending_set[gi]  = pending_reg[gi] | (bus.call_req[gi] & ~(in_door & bus.cur_floor[gi]));
    assign pending_next[gi] = pending_set[gi] & ~(enter_door & bus.cur_floor[gi]);
  end

  always_comb begin
    state_next    = state_reg;
    target_next   = target_reg;
    dir_up_next   = dir_up_reg;
    door_cnt_next = door_cnt_reg;
    enter_door    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|pending_reg) state_next = SELECT;
      end
      SELECT: begin
        // A corrupt floor indication freezes dispatch until it clears.
        if (!sched_error_reg) begin
          if (here_hit) begin
            enter_door = 1'b1;
          end else if (!none) begin
            state_next  = DISPATCH;
            target_next = pick;
            dir_up_next = new_dir;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DISPATCH: begin
        if (bus.move_complete && (bus.cur_floor == target_reg)) enter_door = 1'b1;
      end
      DOOR: begin
        if (bus.over_weight || here_call) begin
          door_cnt_next = DOOR_LOAD;
        end else if (door_cnt_reg <= CW'(1)) begin
          door_cnt_next = '0;
          state_next    = (|pending_set) ? SELECT : IDLE;
        end else begin
          door_cnt_next = door_cnt_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    if (enter_door) begin
      state_next    = DOOR;
      door_cnt_next = DOOR_LOAD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      pending_reg     <= '0;
      target_reg      <= '0;
      dir_up_reg      <= 1'b1;
      door_cnt_reg    <= '0;
      sched_error_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pending_reg     <= pending_next;
      target_reg      <= target_next;
      dir_up_reg      <= dir_up_next;
      door_cnt_reg    <= door_cnt_next;
      sched_error_reg <= ~is_onehot(floor_vec_t'(bus.cur_floor));
    end
  end

  assign bus.target_floor = target_reg;
  assign bus.target_valid = (state_reg == DISPATCH);
  assign bus.dir_up       = dir_up_reg;
  assign bus.door_open    = in_door;
  assign bus.pending      = pending_reg;
  assign bus.busy         = (state_reg != IDLE);
  assign bus.sched_error  = sched_error_reg;

endmodule

// File: tb/tb_pes_elc_sched.sv
// Self-checking bench for pes_elc_sched (NFLOORS=8, DOOR_CYCLES=4).
module tb_pes_elc_sched;
  localparam int NF = 8;
  localparam int DC = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  bit   chk_en;

  pes_elc_sched_if #(.NFLOORS(NF)) bus ();

  pes_elc_sched #(.NFLOORS(NF), .DOOR_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (floor indices, integer timers) -----
  // phase: 0 idle, 1 choosing, 2 travelling, 3 door open
  typedef struct {
    int             phase;
    logic [NF-1:0]  pend;
    int             tgt;
    bit             dir;
    int             left;
    bit             err;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.phase = 0;
    r.pend  = '0;
    r.tgt   = -1;
    r.dir   = 1'b1;
    r.left  = 0;
    r.err   = 1'b0;
    return r;
  endfunction

  function automatic logic [NF-1:0] idx2vec(input int i);
    logic [NF-1:0] v;
    v = '0;
    if (i >= 0 && i < NF) v[i] = 1'b1;
    return v;
  endfunction

  function automatic model_t model_step(input model_t mo, input logic [NF-1:0] call,
                                        input logic [NF-1:0] cur, input bit mc, input bit ow);
    model_t n;
    int     c;
    int     nbits;
    bit     enter;
    bit     found;
    n     = mo;
    c     = -1;
    nbits = 0;
    enter = 1'b0;
    found = 1'b0;
    for (int f = 0; f < NF; f++) if (cur[f]) begin nbits++; c = f; end
    n.err = (nbits != 1);
    for (int f = 0; f < NF; f++)
      if (call[f] && !(mo.phase == 3 && cur[f])) n.pend[f] = 1'b1;
    case (mo.phase)
      0: if (mo.pend != '0) n.phase = 1;
      1: begin
        if (mo.err) begin
          n.phase = 1;
        end else if (c >= 0 && mo.pend[c]) begin
          enter = 1'b1;
        end else begin
          if (mo.dir) begin
            for (int f = c + 1; f < NF; f++) if (!found && mo.pend[f]) begin n.tgt = f; found = 1'b1; end
            for (int f = c - 1; f >= 0; f--) if (!found && mo.pend[f]) begin n.tgt = f; found = 1'b1; n.dir = 1'b0; end
          end else begin
            for (int f = c - 1; f >= 0; f--) if (!found && mo.pend[f]) begin n.tgt = f; found = 1'b1; end
            for (int f = c + 1; f < NF; f++) if (!found && mo.pend[f]) begin n.tgt = f; found = 1'b1; n.dir = 1'b1; end
          end
          n.phase = found ? 2 : 0;
        end
      end
      2: if (mc && cur == idx2vec(mo.tgt)) enter = 1'b1;
      default: begin
        if (ow || (call & cur) != '0) n.left = DC;
        else if (mo.left == 1) begin n.left = 0; n.phase = (n.pend != '0) ? 1 : 0; end
        else n.left = mo.left - 1;
      end
    endcase
    if (enter) begin
      n.phase = 3;
      n.left  = DC;
      for (int f = 0; f < NF; f++) if (cur[f]) n.pend[f] = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_step(m, bus.call_req, bus.cur_floor, bus.move_complete, bus.over_weight);
  end

  // ---------------- checking ----------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (chk_en) begin
      #2;
      check("tv",   32'(bus.target_valid), 32'(m.phase == 2));
      check("door", 32'(bus.door_open),    32'(m.phase == 3));
      check("busy", 32'(bus.busy),         32'(m.phase != 0));
      check("tgt",  32'(bus.target_floor), 32'(idx2vec(m.tgt)));
      check("dir",  32'(bus.dir_up),       32'(m.dir));
      check("pend", 32'(bus.pending),      32'(m.pend));
      check("err",  32'(bus.sched_error),  32'(m.err));
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic wait_tv(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (bus.target_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic count_door(output int n);
    n = 0;
    while (bus.door_open === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic call_once(input logic [NF-1:0] v);
    bus.call_req = v;
    @(negedge clk);
    bus.call_req = '0;
  endtask

  // ---------------- directed sequence -------------------------------------
  initial begin
    bit ok;
    int n;
    bit saw_tv;
    bit saw_door;
    n_checks = 0;
    n_errors = 0;
    chk_en   = 1'b0;
    reset    = 1'b0;
    bus.call_req      = '0;
    bus.cur_floor     = 8'h01;
    bus.move_complete = 1'b0;
    bus.over_weight   = 1'b0;

    // reset held with random inputs
    repeat (5) begin
      @(negedge clk);
      bus.call_req      = 8'($urandom);
      bus.cur_floor     = 8'($urandom);
      bus.move_complete = 1'($urandom);
      bus.over_weight   = 1'($urandom);
      chk_en            = 1'b1;
    end
    @(negedge clk);
    check("rst_tv",   32'(bus.target_valid), 32'h0);
    check("rst_door", 32'(bus.door_open),    32'h0);
    check("rst_pend", 32'(bus.pending),      32'h0);
    check("rst_busy", 32'(bus.busy),         32'h0);
    check("rst_err",  32'(bus.sched_error),  32'h0);
    check("rst_tgt",  32'(bus.target_floor), 32'h0);
    check("rst_dir",  32'(bus.dir_up),       32'h1);
    $display("reset held: outputs idle");
    bus.call_req = '0; bus.cur_floor = 8'h01; bus.move_complete = 1'b0; bus.over_weight = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // basic trip floor 0 -> floor 7
    call_once(8'h80);
    check("trip_pend1", 32'(bus.pending), 32'h80);
    repeat (2) @(negedge clk);
    check("trip_tv3",  32'(bus.target_valid), 32'h1);
    check("trip_tgt3", 32'(bus.target_floor), 32'h80);
    bus.move_complete = 1'b1;                 // wrong floor: ignored
    @(negedge clk);
    check("wrong_mc_tv", 32'(bus.target_valid), 32'h1);
    bus.cur_floor = 8'h80;
    @(negedge clk);
    bus.move_complete = 1'b0;
    check("trip_door", 32'(bus.door_open), 32'h1);
    check("trip_pend", 32'(bus.pending),   32'h0);
    count_door(n);
    check("trip_door_len", 32'(n), 32'd4);
    check("trip_idle", 32'(bus.busy), 32'h0);
    $display("trip to floor 7: door cycles %0d", n);

    // SCAN order from floor 3 with calls at 1 and 6
    bus.cur_floor = 8'h08;
    call_once(8'h42);
    repeat (2) @(negedge clk);
    check("scan_tgt1", 32'(bus.target_floor), 32'h40);
    check("scan_dir1", 32'(bus.dir_up), 32'h1);
    bus.cur_floor = 8'h40; bus.move_complete = 1'b1;
    @(negedge clk);
    bus.move_complete = 1'b0;
    wait_tv(20, ok);
    check("scan_wait_tv", 32'(ok), 32'h1);
    check("scan_tgt2", 32'(bus.target_floor), 32'h02);
    check("scan_dir2", 32'(bus.dir_up), 32'h0);
    bus.cur_floor = 8'h02; bus.move_complete = 1'b1;
    @(negedge clk);
    bus.move_complete = 1'b0;
    wait_idle(20, ok);
    check("scan_wait_idle", 32'(ok), 32'h1);
    $display("scan: served floor 6 then floor 1");

    // same-floor call: door without dispatch
    bus.cur_floor = 8'h10;
    @(negedge clk);
    call_once(8'h10);
    saw_tv = 1'b0; saw_door = 1'b0;
    repeat (12) begin
      if (bus.target_valid === 1'b1) saw_tv = 1'b1;
      if (bus.door_open === 1'b1) saw_door = 1'b1;
      @(negedge clk);
    end
    check("same_no_tv", 32'(saw_tv), 32'h0);
    check("same_door",  32'(saw_door), 32'h1);
    check("same_idle",  32'(bus.busy), 32'h0);
    $display("same-floor call at floor 4 served");

    // over_weight holds the door
    call_once(8'h10);
    repeat (2) @(negedge clk);
    check("ow_door0", 32'(bus.door_open), 32'h1);
    bus.over_weight = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.door_open !== 1'b1) n++;
    end
    check("ow_held", 32'(n), 32'd0);
    bus.over_weight = 1'b0;
    count_door(n);
    check("ow_tail", 32'(n), 32'd4);
    check("ow_idle", 32'(bus.busy), 32'h0);
    $display("over_weight: door tail %0d cycles", n);

    // malformed cur_floor blocks dispatch
    bus.cur_floor = 8'h03;
    @(negedge clk);
    check("err_set", 32'(bus.sched_error), 32'h1);
    call_once(8'h01);
    saw_tv = 1'b0;
    repeat (6) begin
      if (bus.target_valid === 1'b1 || bus.door_open === 1'b1) saw_tv = 1'b1;
      @(negedge clk);
    end
    check("err_no_go", 32'(saw_tv), 32'h0);
    check("err_busy",  32'(bus.busy), 32'h1);
    bus.cur_floor = 8'h01;
    wait_idle(20, ok);
    check("err_recover", 32'(ok), 32'h1);
    check("err_clear", 32'(bus.sched_error), 32'h0);
    $display("sched_error: dispatch blocked then recovered");

    // asynchronous reset in the middle of DISPATCH
    call_once(8'h80);
    repeat (2) @(negedge clk);
    check("ar_tv_before", 32'(bus.target_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("ar_tv",   32'(bus.target_valid), 32'h0);
    check("ar_busy", 32'(bus.busy), 32'h0);
    check("ar_pend", 32'(bus.pending), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    $display("async reset during dispatch");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
